// File: rtl/rgb_to_gray_stream.sv
// RGB-to-luma stream stage: echoes the 4-byte width/height header, then turns
// each packed R,G,B triplet into one 8-bit weighted luma byte for the Sobel stage.
`timescale 1ns/1ps

module rgb_to_gray_stream #(
    parameter int DATA_BITS_IN = 8,
    parameter int R_COEF       = 77,
    parameter int G_COEF       = 150,
    parameter int B_COEF       = 29
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_BITS_IN-1:0] data_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [DATA_BITS_IN-1:0] data_out,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic                    done
);

    localparam logic [15:0] LP_R_COEF = 16'(R_COEF);
    localparam logic [15:0] LP_G_COEF = 16'(G_COEF);
    localparam logic [15:0] LP_B_COEF = 16'(B_COEF);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_CALC = 2'd1,
        ST_PIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_hdr_idx;
    logic [15:0] r_width;
    logic [15:0] r_height;
    logic [31:0] r_total;
    logic [31:0] r_pix_cnt;
    logic [1:0]  r_phase;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_data_out;
    logic        r_valid_out;
    logic        r_done;

    logic        w_free;
    logic        w_drain;
    logic        w_pix_full;
    logic        w_ready_in;
    logic        w_accept;
    logic        w_hdr_accept;
    logic        w_pix_accept;
    logic        w_b_accept;
    logic        w_load;
    logic [7:0]  w_load_data;
    logic        w_valid_next;
    logic        w_done_next;
    logic [31:0] w_product;
    logic [15:0] w_sum;
    logic [7:0]  w_gray;

    assign w_free       = !r_valid_out || ready_out;
    assign w_drain      = r_valid_out && ready_out;
    assign w_pix_full   = (r_pix_cnt == r_total);
    assign w_accept     = valid_in && w_ready_in;
    assign w_hdr_accept = w_accept && (r_state == ST_HDR);
    // Once every pixel has been counted, further bytes are swallowed without effect.
    assign w_pix_accept = w_accept && (r_state == ST_PIX) && !w_pix_full;
    assign w_b_accept   = w_pix_accept && (r_phase == 2'd2);
    assign w_product    = {16'd0, r_width} * {16'd0, r_height};

    // Weights sum to 256, so the 16-bit sum cannot overflow and [15:8] is the luma.
    assign w_sum  = (LP_R_COEF * {8'd0, r_red})
                  + (LP_G_COEF * {8'd0, r_green})
                  + (LP_B_COEF * {8'd0, data_in});
    assign w_gray = w_sum[15:8];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HDR: begin
                if (w_hdr_accept && (r_hdr_idx == 2'd3)) begin
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_HDR;
                end
            end
            ST_CALC: begin
                if (w_product == 32'd0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_PIX;
                end
            end
            ST_PIX: begin
                if (w_pix_full && w_drain) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_PIX;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_HDR;
            end
        endcase
    end

    // Output decode: input handshake, output-register load and done flag
    always_comb begin
        w_ready_in = 1'b0;
        case (r_state)
            ST_HDR: begin
                w_ready_in = w_free;
            end
            ST_CALC: begin
                w_ready_in = 1'b0;
            end
            ST_PIX: begin
                if (w_pix_full) begin
                    w_ready_in = 1'b1;
                end else if (r_phase == 2'd2) begin
                    w_ready_in = w_free;
                end else begin
                    w_ready_in = 1'b1;
                end
            end
            ST_DONE: begin
                w_ready_in = 1'b1;
            end
            default: begin
                w_ready_in = 1'b0;
            end
        endcase

        w_load = w_hdr_accept || w_b_accept;
        if (w_hdr_accept) begin
            w_load_data = data_in;
        end else begin
            w_load_data = w_gray;
        end

        if (w_load) begin
            w_valid_next = 1'b1;
        end else if (w_drain) begin
            w_valid_next = 1'b0;
        end else begin
            w_valid_next = r_valid_out;
        end

        w_done_next = (w_state_next == ST_DONE) && !w_valid_next;
    end

    // Header capture of width and height, little-endian
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_idx <= 2'd0;
            r_width   <= 16'd0;
            r_height  <= 16'd0;
        end else if (w_hdr_accept) begin
            r_hdr_idx <= r_hdr_idx + 2'd1;
            case (r_hdr_idx)
                2'd0:    r_width[7:0]   <= data_in;
                2'd1:    r_width[15:8]  <= data_in;
                2'd2:    r_height[7:0]  <= data_in;
                2'd3:    r_height[15:8] <= data_in;
                default: r_width        <= r_width;
            endcase
        end else begin
            r_hdr_idx <= r_hdr_idx;
        end
    end

    // Frame size, latched during the single CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= 32'd0;
        end else if (r_state == ST_CALC) begin
            r_total <= w_product;
        end else begin
            r_total <= r_total;
        end
    end

    // Triplet phase, colour latches and pixel counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= 2'd0;
            r_red     <= 8'd0;
            r_green   <= 8'd0;
            r_pix_cnt <= 32'd0;
        end else if (w_pix_accept) begin
            case (r_phase)
                2'd0: begin
                    r_red   <= data_in;
                    r_phase <= 2'd1;
                end
                2'd1: begin
                    r_green <= data_in;
                    r_phase <= 2'd2;
                end
                default: begin
                    r_phase   <= 2'd0;
                    r_pix_cnt <= r_pix_cnt + 32'd1;
                end
            endcase
        end else begin
            r_phase <= r_phase;
        end
    end

    // Single-entry output register, held stable until accepted downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= 8'd0;
            r_valid_out <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_out <= w_load_data;
            end else begin
                r_data_out <= r_data_out;
            end
            r_valid_out <= w_valid_next;
            r_done      <= w_done_next;
        end
    end

    assign ready_in  = w_ready_in;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign done      = r_done;

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Scoreboard bench for rgb_to_gray_stream: directed header/pixel vectors with
// hand-computed luma values, checked by an independent output monitor.
`timescale 1ns/1ps

module tb_rgb_to_gray_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_out = 1'b1;
    logic       done;

    int         n_pass = 0;
    int         n_total = 0;
    int         n_xfer = 0;
    logic [7:0] exp_q[$];
    longint     t_q[$];

    rgb_to_gray_stream #(
        .DATA_BITS_IN(8),
        .R_COEF(77),
        .G_COEF(150),
        .B_COEF(29)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every downstream transfer is popped from the scoreboard
    always @(negedge clk) begin
        if (valid_out === 1'b1 && ready_out === 1'b1) begin
            n_xfer++;
            t_q.push_back(longint'($time));
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got 0x%0h, required no transfer", data_out);
            end else begin
                check("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end 2ns after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   t;
        t        = 0;
        acc      = 1'b0;
        data_in  = b;
        valid_in = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #2;
            t++;
        end
        valid_in = 1'b0;
        if (!acc) begin
            check("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_hdr(input logic [15:0] w, input logic [15:0] h);
        logic [7:0] hb[4];
        hb[0] = w[7:0];
        hb[1] = w[15:8];
        hb[2] = h[7:0];
        hb[3] = h[15:8];
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(hb[i]);
            send_byte(hb[i]);
        end
    endtask

    task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [7:0] gray, input bit lat);
        send_byte(r);
        send_byte(g);
        exp_q.push_back(gray);
        send_byte(b);
        if (lat) begin
            #3;
            check("gray_latency_valid", {31'd0, valid_out}, 32'd1);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (done !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, done}, 32'd1);
        check({name, "_valid_low"}, {31'd0, valid_out}, 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic end_test(input string name, input int n0, input int exp_n);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
        check({name, "_xfer_count"}, n_xfer - n0, exp_n);
    endtask

    initial begin
        int n0;

        // Reset state
        do_reset();
        #3;
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready_in", {31'd0, ready_in}, 32'd1);
        @(posedge clk);
        #2;

        // 1: 3x2 frame
        n0 = n_xfer;
        send_hdr(16'd3, 16'd2);
        send_pix(8'd128, 8'd64,  8'd32,  8'd79,  1'b0);
        send_pix(8'd200, 8'd100, 8'd50,  8'd124, 1'b0);
        send_pix(8'd16,  8'd32,  8'd48,  8'd29,  1'b0);
        send_pix(8'd255, 8'd128, 8'd0,   8'd151, 1'b0);
        send_pix(8'd50,  8'd150, 8'd250, 8'd131, 1'b0);
        send_pix(8'd7,   8'd7,   8'd7,   8'd7,   1'b0);
        #3;
        check("t1_done_early", {31'd0, done}, 32'd0);
        @(posedge clk);
        #2;
        wait_done("t1_done");
        end_test("t1", n0, 10);

        // 2: extreme colours in a 5x1 frame, 1-cycle latency
        do_reset();
        n0 = n_xfer;
        send_hdr(16'd5, 16'd1);
        send_pix(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        send_pix(8'd0,   8'd0,   8'd0,   8'd0,   1'b1);
        send_pix(8'd255, 8'd0,   8'd0,   8'd76,  1'b1);
        send_pix(8'd0,   8'd255, 8'd0,   8'd149, 1'b1);
        send_pix(8'd0,   8'd0,   8'd255, 8'd28,  1'b1);
        wait_done("t2_done");
        end_test("t2", n0, 9);

        // 3: downstream backpressure on the first gray byte
        do_reset();
        n0 = n_xfer;
        send_hdr(16'd2, 16'd1);
        repeat (3) @(posedge clk);
        #2;
        ready_out = 1'b0;
        send_pix(8'd255, 8'd128, 8'd0, 8'd151, 1'b0);
        send_byte(8'd50);
        send_byte(8'd150);
        exp_q.push_back(8'd131);
        data_in  = 8'd250;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_data", {24'd0, data_out}, 32'd151);
            check("t3_hold_valid", {31'd0, valid_out}, 32'd1);
            check("t3_b_stall", {31'd0, ready_in}, 32'd0);
            @(posedge clk);
            #2;
        end
        ready_out = 1'b1;
        send_byte(8'd250);
        wait_done("t3_done");
        end_test("t3", n0, 6);

        // 4: zero-height frame
        do_reset();
        n0 = n_xfer;
        send_hdr(16'd4, 16'd0);
        @(negedge clk);
        check("t4_done_calc", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("t4_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #2;
        send_byte(8'd11);
        send_byte(8'd22);
        send_byte(8'd33);
        repeat (3) @(posedge clk);
        #3;
        check("t4_no_valid", {31'd0, valid_out}, 32'd0);
        check("t4_done_held", {31'd0, done}, 32'd1);
        @(posedge clk);
        #2;
        end_test("t4", n0, 4);

        // 5: reset in the middle of the second pixel, then a fresh 1x1 frame
        do_reset();
        send_hdr(16'd3, 16'd1);
        send_pix(8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
        send_byte(8'd16);
        send_byte(8'd32);
        check("t5_pre_rst_queue", exp_q.size(), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #3;
        check("t5_rst_data", {24'd0, data_out}, 32'd0);
        check("t5_rst_valid", {31'd0, valid_out}, 32'd0);
        check("t5_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #2;
        n0 = n_xfer;
        send_hdr(16'd1, 16'd1);
        send_pix(8'd10, 8'd20, 8'd30, 8'd18, 1'b0);
        wait_done("t5_done");
        end_test("t5", n0, 5);

        // 6: back-to-back input over a 2x2 frame
        do_reset();
        t_q.delete();
        n0 = n_xfer;
        send_hdr(16'd2, 16'd2);
        send_pix(8'd0,   8'd0,   8'd0,   8'd0,   1'b0);
        send_pix(8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send_pix(8'd16,  8'd32,  8'd48,  8'd29,  1'b0);
        send_pix(8'd200, 8'd100, 8'd50,  8'd124, 1'b0);
        wait_done("t6_done");
        end_test("t6", n0, 8);
        if (t_q.size() >= 8) begin
            for (int i = 0; i < 3; i++) begin
                check("t6_hdr_spacing", 32'(t_q[i+1] - t_q[i]), 32'd10);
            end
            for (int i = 4; i < 7; i++) begin
                check("t6_gray_spacing", 32'(t_q[i+1] - t_q[i]), 32'd30);
            end
        end else begin
            check("t6_timestamps", t_q.size(), 32'd8);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
